// File: rtl/dmem_responder.sv
// =============================================================================
// dmem_responder: single-outstanding RV32 data-memory responder, LATENCY-cycle
// response. Optional DMEM_ALIGN_CHECK_EN flags misaligned accesses as errors.
// Revision: 1.0
// =============================================================================
`default_nettype none

module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         DATA_MEM_ADDR_WIDTH = $clog2(DEPTH);
   localparam bit         DIRECT              = (LATENCY == 1);
   localparam logic [2:0] CNT_INIT            = 3'(LATENCY > 1 ? LATENCY - 2 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q, wdata_q;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] mem_q [DEPTH];

   logic        accept, access_en, mem_we, acc_err, illegal, out_of_range;
   logic        a_we;
   logic [2:0]  a_f3;
   logic [31:0] a_addr, a_wdata, rword, shifted, load_data, wlane;
   logic [1:0]  off;
   logic [3:0]  be;

   assign req_ready = (state_q == S_IDLE);
   assign accept    = req_valid && req_ready;
   assign access_en = (accept && DIRECT) || ((state_q == S_WAIT) && (cnt_q == 3'd0));

   // With LATENCY==1 the access happens on the accepting edge, so use live inputs.
   assign a_we    = (state_q == S_IDLE) ? req_we     : we_q;
   assign a_f3    = (state_q == S_IDLE) ? req_funct3 : funct3_q;
   assign a_addr  = (state_q == S_IDLE) ? req_addr   : addr_q;
   assign a_wdata = (state_q == S_IDLE) ? req_wdata  : wdata_q;

   always_comb begin
      case (a_f3)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = a_we;
         default:                illegal = 1'b1;
      endcase
      out_of_range = ({2'b00, a_addr[31:2]} >= 32'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
      acc_err = illegal || out_of_range ||
                ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
                ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
`else
      acc_err = illegal || out_of_range;
`endif
      off = a_addr[1:0];
      if (a_f3[1:0] == 2'b01) off[0] = 1'b0;
      if (a_f3[1:0] == 2'b10) off    = 2'b00;

      rword   = mem_q[a_addr[DATA_MEM_ADDR_WIDTH+1:2]];
      shifted = rword >> {off, 3'b000};
      case (a_f3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = rword;
      endcase

      case (a_f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      wlane  = a_wdata << {off, 3'b000};
      mem_we = access_en && a_we && !acc_err && rst_n;
   end

   // Array has no reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[a_addr[DATA_MEM_ADDR_WIDTH+1:2]][8*b +: 8] <= wlane[8*b +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (DIRECT) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (access_en) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = acc_err;
         rsp_rdata_d = (acc_err || a_we) ? 32'd0 : load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         we_q        <= 1'b0;
         funct3_q    <= 3'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire
